// File: rtl/dport_sram.sv
// Data-port slave: checks each load/store, performs one SRAM word access and
// returns load data or fault responses through a credit-guarded response FIFO.
module dport_sram #(
  parameter int unsigned C_SRAM_ADDR_X = 10,
  parameter logic [31:0] C_BASE_ADDR   = 32'h0001_0000,
  parameter logic [1:0]  C_WR_MIN_HPL  = 2'd0,
  parameter int unsigned C_RSP_DEPTH   = 4
) (
  input  logic                     clk_i,
  input  logic                     resetb_i,
  input  logic                     clk_en_i,
  output logic                     dreqready_o,
  input  logic                     dreqvalid_i,
  input  logic                     dreqdvalid_i,
  input  logic [1:0]               dreqhpl_i,
  input  logic [31:0]              dreqaddr_i,
  input  logic [31:0]              dreqdata_i,
  input  logic                     drspready_i,
  output logic                     drspvalid_o,
  output logic                     drsprerr_o,
  output logic                     drspwerr_o,
  output logic [31:0]              drspdata_o,
  output logic                     sram_ce_o,
  output logic                     sram_we_o,
  output logic [C_SRAM_ADDR_X-1:0] sram_addr_o,
  output logic [31:0]              sram_wdata_o,
  input  logic [31:0]              sram_rdata_i
);
  localparam int unsigned LP_PTR_W = (C_RSP_DEPTH > 1) ? $clog2(C_RSP_DEPTH) : 1;
  localparam int unsigned LP_CNT_W = $clog2(C_RSP_DEPTH + 1);
  localparam logic [32:0] LP_WIN_LO = {1'b0, C_BASE_ADDR};
  localparam logic [32:0] LP_WIN_HI = LP_WIN_LO + (33'd1 << (C_SRAM_ADDR_X + 2));
  localparam logic [LP_PTR_W-1:0] LP_PTR_LAST = LP_PTR_W'(C_RSP_DEPTH - 1);
  localparam logic [LP_CNT_W:0]   LP_DEPTH    = (LP_CNT_W + 1)'(C_RSP_DEPTH);
  // Bit i set when privilege level i may store.
  localparam logic [3:0] LP_HPL_OK = 4'b1111 << C_WR_MIN_HPL;

  logic                run_q;
  logic                s1_v_q, s1_v_d, s1_load_q, s1_load_d, s1_fault_q, s1_fault_d;
  logic [31:0]         s1_addr_q, s1_addr_d;
  logic [LP_PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LP_CNT_W-1:0] count_q, count_d;
  logic                rsp_rerr_q [C_RSP_DEPTH];
  logic                rsp_werr_q [C_RSP_DEPTH];
  logic [31:0]         rsp_data_q [C_RSP_DEPTH];

  logic        in_win_s, fault_s, accept_s, ready_s, empty_s, push_s, pop_s;
  logic        new_rerr_s, new_werr_s;
  logic [31:0] new_data_s;
  logic [LP_CNT_W:0] occ_s;

  always_comb begin
    in_win_s = ({1'b0, dreqaddr_i} >= LP_WIN_LO) && ({1'b0, dreqaddr_i} < LP_WIN_HI);
    fault_s  = (dreqaddr_i[1:0] != 2'b00) || !in_win_s ||
               (dreqdvalid_i && !LP_HPL_OK[dreqhpl_i]);
    // Occupancy counts the response still waiting in s1; a same-cycle pop earns no credit.
    occ_s    = {1'b0, count_q} + {{LP_CNT_W{1'b0}}, s1_v_q};
    ready_s  = occ_s < LP_DEPTH;
    accept_s = dreqvalid_i && ready_s && clk_en_i && run_q;
    empty_s  = (count_q == {LP_CNT_W{1'b0}});
    push_s   = clk_en_i && s1_v_q;
    pop_s    = clk_en_i && !empty_s && drspready_i;
    new_rerr_s = s1_load_q && s1_fault_q;
    new_werr_s = !s1_load_q && s1_fault_q;
    new_data_s = s1_fault_q ? s1_addr_q : sram_rdata_i;
  end

  assign dreqready_o  = ready_s;
  assign sram_ce_o    = accept_s && !fault_s;
  assign sram_we_o    = accept_s && !fault_s && dreqdvalid_i;
  assign sram_addr_o  = dreqaddr_i[2 +: C_SRAM_ADDR_X];
  assign sram_wdata_o = dreqdata_i;
  assign drspvalid_o  = !empty_s;
  assign drsprerr_o   = !empty_s && rsp_rerr_q[rd_ptr_q];
  assign drspwerr_o   = !empty_s && rsp_werr_q[rd_ptr_q];
  assign drspdata_o   = empty_s ? 32'h0 : rsp_data_q[rd_ptr_q];

  always_comb begin
    s1_v_d     = s1_v_q;
    s1_load_d  = s1_load_q;
    s1_fault_d = s1_fault_q;
    s1_addr_d  = s1_addr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (clk_en_i) begin
      s1_v_d = accept_s && (!dreqdvalid_i || fault_s);
    end else begin
      s1_v_d = s1_v_q;
    end
    if (accept_s) begin
      s1_load_d  = !dreqdvalid_i;
      s1_fault_d = fault_s;
      s1_addr_d  = dreqaddr_i;
    end else begin
      s1_addr_d  = s1_addr_q;
    end
    if (push_s) begin
      wr_ptr_d = (wr_ptr_q == LP_PTR_LAST) ? {LP_PTR_W{1'b0}} : wr_ptr_q + LP_PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = (rd_ptr_q == LP_PTR_LAST) ? {LP_PTR_W{1'b0}} : rd_ptr_q + LP_PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + LP_CNT_W'(1);
      2'b01:   count_d = count_q - LP_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // run_q keeps the strobe quiet between reset release and the first clock edge.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      run_q      <= 1'b0;
      s1_v_q     <= 1'b0;
      s1_load_q  <= 1'b0;
      s1_fault_q <= 1'b0;
      s1_addr_q  <= 32'h0;
      wr_ptr_q   <= {LP_PTR_W{1'b0}};
      rd_ptr_q   <= {LP_PTR_W{1'b0}};
      count_q    <= {LP_CNT_W{1'b0}};
    end else begin
      run_q      <= 1'b1;
      s1_v_q     <= s1_v_d;
      s1_load_q  <= s1_load_d;
      s1_fault_q <= s1_fault_d;
      s1_addr_q  <= s1_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      for (int i = 0; i < int'(C_RSP_DEPTH); i++) begin
        rsp_rerr_q[i] <= 1'b0;
        rsp_werr_q[i] <= 1'b0;
        rsp_data_q[i] <= 32'h0;
      end
    end else if (push_s) begin
      rsp_rerr_q[wr_ptr_q] <= new_rerr_s;
      rsp_werr_q[wr_ptr_q] <= new_werr_s;
      rsp_data_q[wr_ptr_q] <= new_data_s;
    end
  end
endmodule

// File: doc/dport_sram.md
# dport_sram

Data-port slave that terminates the load/store queue's `dreq*`/`drsp*` handshake on a single-port synchronous SRAM. It sits directly downstream of the load/store queue. Each accepted request is checked for alignment, address window and store privilege. Legal requests become one SRAM word access; the block returns load data, or a fault response carrying the bad address, through a small response buffer with backpressure. Accesses are word-only; there is no byte/halfword lane handling.

## Interface
Parameters:
- `C_SRAM_ADDR_X`, default 10: SRAM word-address width. The window is 4·2^X bytes.
- `C_BASE_ADDR`, default 32'h0001_0000: byte base of the window. Must be aligned to the window size.
- `C_WR_MIN_HPL`, default 2'd0: minimum `dreqhpl_i` permitted for stores.
- `C_RSP_DEPTH`, default 4: response buffer entries (≥3).

Ports:
- `clk_i`  in  1  clock. One clock domain.
- `resetb_i`  in  1  asynchronous active-low reset.
- `clk_en_i`  in  1  global clock enable. All state holds while low.
- `dreqready_o`  out  1  request accepted when `dreqvalid_i & dreqready_o & clk_en_i`.
- `dreqvalid_i`  in  1  request valid.
- `dreqdvalid_i`  in  1  1 = store, 0 = load.
- `dreqhpl_i`  in  2  hart privilege level of the request.
- `dreqaddr_i`  in  32  byte address.
- `dreqdata_i`  in  32  store data.
- `drspready_i`  in  1  response consumer ready.
- `drspvalid_o`  out  1  response valid.
- `drsprerr_o`  out  1  load access fault.
- `drspwerr_o`  out  1  store access fault.
- `drspdata_o`  out  32  load data, or faulting address.
- `sram_ce_o`  out  1  SRAM access strobe.
- `sram_we_o`  out  1  SRAM write.
- `sram_addr_o`  out  C_SRAM_ADDR_X  SRAM word address, `dreqaddr_i[2 +: X]`.
- `sram_wdata_o`  out  32  equals `dreqdata_i`.
- `sram_rdata_i`  in  32  read data, valid the cycle after a read strobe.

## Operation
- Accept = `dreqvalid_i & dreqready_o & clk_en_i`.
- Fault = `addr[1:0]!=0` OR `addr` outside `[C_BASE_ADDR, C_BASE_ADDR+4·2^X)` OR (store AND `hpl < C_WR_MIN_HPL`). The comparison is unsigned.
- SRAM strobe: `sram_ce_o = accept & ~fault`, combinational in the accept cycle. `sram_we_o = sram_ce_o & dreqdvalid_i`.
- Stage-1 register (`s1`) captures, on accept, `{v, load, fault, addr}`. `v` is set only for requests that produce a response: all loads, and faulting stores. Successful stores produce no response.
- Next enabled cycle, `s1` pushes one buffer entry:
  - good load: `{rerr=0, werr=0, data=sram_rdata_i}`
  - faulting load: `{rerr=1, werr=0, data=addr}`
  - faulting store: `{rerr=0, werr=1, data=addr}`
- Response buffer is a FIFO of depth `C_RSP_DEPTH`. `drsp*_o` present the head entry and `drspvalid_o = ~empty`. Pop = `drspvalid_o & drspready_i & clk_en_i`.
- Credit rule: `dreqready_o = (count + s1.v) < C_RSP_DEPTH`, where `count` is the current occupancy and a pop in the same cycle is not credited. The buffer therefore never overflows and `sram_rdata_i` is never dropped.
- Responses return in request order.
- Simultaneous push and pop leaves `count` unchanged.
- Pointers wrap modulo `C_RSP_DEPTH`.

## Timing
- Reset (async assert, no clock needed): `s1.v=0`, buffer empty.
- Output values in reset: `dreqready_o=1`, `drspvalid_o=0`, `drsprerr_o=0`, `drspwerr_o=0`, `drspdata_o=0`, `sram_ce_o=0`, `sram_we_o=0`. `sram_addr_o` and `sram_wdata_o` follow their inputs.
- Reset assertion mid-operation discards `s1` and all buffered responses. A read strobe in that cycle is ignored.
- Latency: request accepted at cycle N gives `drspvalid_o` at N+2 if the buffer was empty.
- Store write occurs at the clock edge ending cycle N.
- Throughput: one request per cycle sustained while `drspready_i=1`.
- With `drspready_i=0`, a load stream stalls after exactly `C_RSP_DEPTH` loads are accepted (`dreqready_o` low).
- `clk_en_i=0`:
  - no accept, `sram_ce_o=0`, no push or pop
  - SRAM output is assumed held; read data captured in the prior enabled cycle stays registered.
- Response outputs are stable while `drspvalid_o & ~drspready_i`.

## Test plan
- Reset with `dreqvalid_i=1` -> all outputs at reset values. After release, `dreqready_o=1` and no `sram_ce_o` until the first edge.
- Store `addr=32'h0001_0010 data=32'hDEADBEEF`, then load from the same address -> one SRAM write at word 4. No response for the store. Load response `drspdata_o=32'hDEADBEEF` with `rerr=0` at accept+2.
- Load `addr=32'h0001_0002` and load `addr=32'h0002_0000` -> no `sram_ce_o`. Two responses with `rerr=1`, data `32'h0001_0002` then `32'h0002_0000`.
- `C_WR_MIN_HPL=3`: store with `hpl=0` to `32'h0001_0000` -> no write. Response `werr=1`, `drspdata_o=32'h0001_0000`.
- Hold `drspready_i=0`, offer 6 back-to-back loads -> exactly 4 accepted and `dreqready_o` low. Raising `drspready_i` drains 4 in order, then accepts the remaining 2.
- 100 back-to-back loads with `drspready_i=1` -> `dreqready_o` never drops, one response per cycle, data in address order.
